imem_loader: RTL and testbench

Program loader for the pipelined `micro` core's instruction memory. It accepts a framed byte stream on a valid/ready interface and assembles 16-bit instruction words. It writes each word to consecutive instruction-memory addresses, then releases the core from reset. It replaces hierarchical memory pokes and `.coe`/`.mif` initialisation for hardware bring-up, and sits between a byte source (UART receiver or host bridge) and the instruction-memory write port.

---
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the micro core instruction memory.
// Assembles big-endian 16-bit words, writes them, then releases the core.
module imem_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [15:0]       Mem_wdata,
  output logic              Cpu_rst,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [7:0]        left;
  logic [7:0]        sum;
  logic [7:0]        hi;
  logic [ADDR_W-1:0] addr;
  logic              take;

  // Gated by reset so the source sees no acceptance while held in reset.
  assign In_ready = Rst & (state != S_WRITE);
  assign take     = In_valid & In_ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= S_IDLE;
      left      <= '0;
      sum       <= '0;
      hi        <= '0;
      addr      <= '0;
      Mem_we    <= 1'b0;
      Mem_addr  <= '0;
      Mem_wdata <= '0;
      Cpu_rst   <= 1'b1;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (take && In_data == SYNC) begin
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (take) begin
            left  <= In_data;
            sum   <= In_data;
            addr  <= '0;
            state <= (In_data == 8'd0) ? S_CHECK : S_HI;
          end
        end
        S_HI: begin
          if (take) begin
            hi    <= In_data;
            sum   <= sum ^ In_data;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (take) begin
            sum       <= sum ^ In_data;
            Mem_wdata <= {hi, In_data};
            Mem_addr  <= addr;
            Mem_we    <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          addr  <= addr + 1'b1;
          left  <= left - 8'd1;
          state <= (left == 8'd1) ? S_CHECK : S_HI;
        end
        S_CHECK: begin
          if (take) begin
            if (In_data == sum) begin
              state   <= S_DONE;
              Done    <= 1'b1;
              Cpu_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              Error <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (take && In_data == SYNC) begin
            state   <= S_COUNT;
            Cpu_rst <= 1'b1;
            Done    <= 1'b0;
            Error   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a frame-level reference model.
// Writes are scoreboarded every cycle; status checked after each frame.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [7:0]  In_data = 8'h00;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic        Mem_we;
  logic [7:0]  Mem_addr;
  logic [15:0] Mem_wdata;
  logic        Cpu_rst;
  logic        Done;
  logic        Error;

  imem_loader #(.ADDR_W(8), .SYNC(8'hA5)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .In_data  (In_data),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .Mem_we   (Mem_we),
    .Mem_addr (Mem_addr),
    .Mem_wdata(Mem_wdata),
    .Cpu_rst  (Cpu_rst),
    .Done     (Done),
    .Error    (Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  wr_t         exp_q[$];
  logic [15:0] mem[256];
  logic        exp_done = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_cpu = 1'b1;
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Frame-level model: scan for sync, take N, pair bytes, xor-check.
  task automatic model(input logic [7:0] b[$]);
    int i = 0;
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin
        i++;
      end else begin
        int n;
        logic [7:0] x;
        n = int'(b[i+1]);
        x = b[i+1];
        exp_cpu = 1'b1;
        exp_done = 1'b0;
        exp_err = 1'b0;
        for (int k = 0; k < n; k++) begin
          wr_t w;
          w.a = 8'(k);
          w.d = {b[i+2+2*k], b[i+3+2*k]};
          x = x ^ b[i+2+2*k] ^ b[i+3+2*k];
          exp_q.push_back(w);
        end
        if (x == b[i+2+2*n]) begin
          exp_done = 1'b1;
          exp_cpu = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
        i += 3 + 2 * n;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      In_valid = 1'b0;
      repeat (gap) @(negedge Clk);
    end
    In_data = b;
    In_valid = 1'b1;
    while (!In_ready && t < 8) begin
      @(negedge Clk);
      t++;
    end
    chk("accept", In_ready, 1);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic send_all(input logic [7:0] b[$], input int mg);
    foreach (b[i]) begin
      send(b[i], (mg == 0) ? 0 : int'($urandom_range(mg, 0)));
    end
    In_valid = 1'b0;
  endtask

  task automatic status(input string tag);
    chk({tag, "_done"}, Done, exp_done);
    chk({tag, "_error"}, Error, exp_err);
    chk({tag, "_cpu_rst"}, Cpu_rst, exp_cpu);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, In_ready, 0);
    chk({tag, "_we"}, Mem_we, 0);
    chk({tag, "_addr"}, Mem_addr, 0);
    chk({tag, "_wdata"}, Mem_wdata, 0);
    chk({tag, "_cpu_rst"}, Cpu_rst, 1);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_error"}, Error, 0);
  endtask

  always @(negedge Clk) begin
    if (Rst) begin
      chk("ready_decode", In_ready, !Mem_we);
      chk("we_pulse", prev_we & Mem_we, 0);
      if (Mem_we) begin
        wr_cnt++;
        mem[Mem_addr] = Mem_wdata;
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", Mem_addr, w.a);
          chk("wr_data", Mem_wdata, w.d);
        end
      end
    end
    prev_we = Rst & Mem_we;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    logic [7:0] f3[$];
    logic [7:0] f4[$];
    logic [7:0] f5[$];
    logic [7:0] p6[$];
    logic [7:0] f6[$];
    int w0;

    f1 = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    f2 = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0B};
    f3 = '{8'h00, 8'hFF, 8'hA6, 8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67};
    f4 = '{8'hA5, 8'h00, 8'h00};
    f5 = '{8'h01, 8'h00, 8'h01, 8'h00};
    p6 = '{8'hA5, 8'h02, 8'h12};
    f6 = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h32};

    #12;
    reset_vals("por");
    @(negedge Clk);
    #3 Rst = 1'b1;
    @(negedge Clk);
    chk("idle_ready", In_ready, 1);

    model(f1);
    chk("model_w0", exp_q[0].d, 16'h1234);
    chk("model_w1", exp_q[1].d, 16'h5678);
    chk("model_t1_done", exp_done, 1);
    send_all(f1, 0);
    status("t1");
    chk("t1_mem0", mem[0], 16'h1234);
    chk("t1_mem1", mem[1], 16'h5678);
    chk("t1_done_lit", Done, 1);

    mem[0] = 16'h0;
    mem[1] = 16'h0;
    model(f2);
    chk("model_t2_err", exp_err, 1);
    send_all(f2, 0);
    status("t2");
    chk("t2_mem0", mem[0], 16'h1234);
    chk("t2_mem1", mem[1], 16'h5678);
    chk("t2_error_lit", Error, 1);

    mem[0] = 16'h0;
    w0 = wr_cnt;
    model(f3);
    send_all(f3, 0);
    status("t3");
    chk("t3_mem0", mem[0], 16'hABCD);
    chk("t3_writes", wr_cnt - w0, 1);

    w0 = wr_cnt;
    model(f4);
    send_all(f4, 0);
    status("t4");
    chk("t4_writes", wr_cnt - w0, 0);
    chk("t4_cpu_rst_lit", Cpu_rst, 0);

    mem[0] = 16'hFFFF;
    f5.push_front(8'hA5);
    model(f5);
    void'(f5.pop_front());
    send(8'hA5, 0);
    chk("t5_sync_cpu_rst", Cpu_rst, 1);
    chk("t5_sync_done", Done, 0);
    send_all(f5, 0);
    status("t5");
    chk("t5_mem0", mem[0], 16'h0001);

    send_all(p6, 0);
    #2 Rst = 1'b0;
    #1;
    reset_vals("mid");
    exp_cpu = 1'b1;
    exp_done = 1'b0;
    exp_err = 1'b0;
    @(negedge Clk);
    #3 Rst = 1'b1;
    @(negedge Clk);
    mem[0] = 16'h0;
    model(f6);
    send_all(f6, 0);
    status("t6");
    chk("t6_mem0", mem[0], 16'h1122);

    mem[0] = 16'h0;
    mem[1] = 16'h0;
    model(f1);
    send_all(f1, 3);
    repeat (2) @(negedge Clk);
    status("t7");
    chk("t7_mem0", mem[0], 16'h1234);
    chk("t7_mem1", mem[1], 16'h5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
